prd_meter: RTL and testbench

//  Parametrised period meter for the digital-transducer front end. It measures the
//  clk-cycle distance between successive single-cycle edge pulses.

---
 rtl/prd_meter_pkg.sv | 24 ++
 rtl/prd_meter_if.sv | 23 ++
 rtl/prd_win_timer.sv | 25 ++
 rtl/prd_meter.sv | 112 +++++++++++
 tb/tb_prd_meter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prd_meter_pkg.sv
// Shared definitions for the period meter: mode encodings and reduction kinds.
// The display and conversion blocks use the same MODE_* codes.
package prd_meter_pkg;

  localparam logic [1:0] MODE_MAX  = 2'b00;
  localparam logic [1:0] MODE_MIN  = 2'b01;
  localparam logic [1:0] MODE_LAST = 2'b10;

  typedef enum logic [1:0] {
    RED_MAX,
    RED_MIN,
    RED_LAST
  } red_e;

  // Code 2'b11 is folded onto max so a stray mode value still gives a sane statistic.
  function automatic red_e decode_mode(logic [1:0] m);
    case (m)
      MODE_MIN:  return RED_MIN;
      MODE_LAST: return RED_LAST;
      default:   return RED_MAX;
    endcase
  endfunction

endpackage

// File: rtl/prd_meter_if.sv
// Edge/mode inputs and published statistic of the period meter.
interface prd_meter_if #(
  parameter int CNT_W  = 32,
  parameter int EDGE_W = 16
);
  logic              edge_i;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  prd;
  logic [EDGE_W-1:0] edges;
  logic              valid;
  logic              no_edge;
  logic              ovf;

  modport master (
    output edge_i, mode,
    input  prd, edges, valid, no_edge, ovf
  );

  modport slave (
    input  edge_i, mode,
    output prd, edges, valid, no_edge, ovf
  );
endinterface

// File: rtl/prd_win_timer.sv
// Free-running window counter 0..WIN_CYC-1 with a one-cycle win_end on the last count.
module prd_win_timer #(
  parameter int WIN_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic win_end
);

  localparam int WC_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WIN_CYC - 1);

  logic [WC_W-1:0] wcnt_q, wcnt_d;

  always_comb begin
    win_end = (wcnt_q == WC_LAST);
    wcnt_d  = win_end ? '0 : wcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt_q <= '0;
    else        wcnt_q <= wcnt_d;
  end

endmodule

// File: rtl/prd_meter.sv
// Period meter: measures clk cycles between edge pulses and publishes max/min/last
// of those periods, plus sample count and flags, once per window.
module prd_meter
  import prd_meter_pkg::*;
#(
  parameter int WIN_CYC = 10_000_000,
  parameter int CNT_W   = 32,
  parameter int EDGE_W  = 16
) (
  input logic        clk,
  input logic        rst_n,
  prd_meter_if.slave bus
);

  logic win_end;

  prd_win_timer #(.WIN_CYC(WIN_CYC)) u_win_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .win_end (win_end)
  );

  logic [CNT_W-1:0]  pcnt_q, pcnt_d, acc_q, acc_d, prd_q, prd_d;
  logic [EDGE_W-1:0] ecnt_q, ecnt_d, edges_q, edges_d;
  logic              armed_q, armed_d, ovf_acc_q, ovf_acc_d;
  logic              valid_q, valid_d, no_edge_q, no_edge_d, ovf_q, ovf_d;
  red_e              mode_q, mode_d;

  logic              sample_vld, sample_sat;
  logic [CNT_W-1:0]  sample, acc_nx;
  logic [EDGE_W-1:0] ecnt_nx;
  logic              ovf_nx;

  always_comb begin
    sample_sat = &pcnt_q;
    sample     = sample_sat ? pcnt_q : pcnt_q + 1'b1;
    sample_vld = bus.edge_i & armed_q;
    pcnt_d     = bus.edge_i ? '0 : sample;
    armed_d    = armed_q | bus.edge_i;

    // *_nx already include a sample landing on the win_end cycle.
    acc_nx  = acc_q;
    ecnt_nx = ecnt_q;
    ovf_nx  = ovf_acc_q;
    if (sample_vld) begin
      case (mode_q)
        RED_MIN:  if (sample < acc_q) acc_nx = sample;
        RED_LAST: acc_nx = sample;
        default:  if (sample > acc_q) acc_nx = sample;
      endcase
      ecnt_nx = (&ecnt_q) ? ecnt_q : ecnt_q + 1'b1;
      ovf_nx  = ovf_acc_q | sample_sat;
    end

    acc_d     = acc_nx;
    ecnt_d    = ecnt_nx;
    ovf_acc_d = ovf_nx;
    mode_d    = mode_q;
    prd_d     = prd_q;
    edges_d   = edges_q;
    no_edge_d = no_edge_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;

    if (win_end) begin
      prd_d     = (ecnt_nx == '0) ? '0 : acc_nx;
      edges_d   = ecnt_nx;
      no_edge_d = (ecnt_nx == '0);
      ovf_d     = ovf_nx;
      valid_d   = 1'b1;
      mode_d    = decode_mode(bus.mode);
      acc_d     = (mode_d == RED_MIN) ? '1 : '0;
      ecnt_d    = '0;
      ovf_acc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q    <= '0;
      armed_q   <= 1'b0;
      acc_q     <= '0;
      ecnt_q    <= '0;
      ovf_acc_q <= 1'b0;
      mode_q    <= RED_MAX;
      prd_q     <= '0;
      edges_q   <= '0;
      no_edge_q <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      armed_q   <= armed_d;
      acc_q     <= acc_d;
      ecnt_q    <= ecnt_d;
      ovf_acc_q <= ovf_acc_d;
      mode_q    <= mode_d;
      prd_q     <= prd_d;
      edges_q   <= edges_d;
      no_edge_q <= no_edge_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.prd     = prd_q;
  assign bus.edges   = edges_q;
  assign bus.valid   = valid_q;
  assign bus.no_edge = no_edge_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_prd_meter.sv
// Bench for prd_meter: cycle-by-cycle reference model, vector table, directed corners
// and a random phase; a second 8-bit instance covers period saturation.
module tb_prd_meter;

  localparam int     W    = 100;
  localparam int     CW   = 32;
  localparam int     EW   = 16;
  localparam longint MAXV = (64'd1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  prd_meter_if #(.CNT_W(CW), .EDGE_W(EW)) bus  ();
  prd_meter_if #(.CNT_W(8),  .EDGE_W(EW)) bus8 ();

  prd_meter #(.WIN_CYC(W), .CNT_W(CW), .EDGE_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  prd_meter #(.WIN_CYC(1000), .CNT_W(8), .EDGE_W(EW)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8));

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: keeps the window's periods in a queue and reduces at close.
  longint   m_cyc = 0, m_last = 0;
  bit       m_armed = 0, m_ovf = 0;
  longint   m_q[$];
  logic [1:0] m_mode = 2'b00;
  longint   e_prd = 0;
  int       e_edges = 0;
  bit       e_valid = 0, e_no_edge = 0, e_ovf = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cyc = 0; m_last = 0; m_armed = 0; m_ovf = 0; m_q.delete(); m_mode = 2'b00;
      e_prd = 0; e_edges = 0; e_valid = 0; e_no_edge = 0; e_ovf = 0;
    end else begin
      e_valid = 0;
      if (bus.edge_i === 1'b1) begin
        if (m_armed) begin
          longint dt;
          dt = m_cyc - m_last;
          if (dt > MAXV) begin
            m_q.push_back(MAXV);
            m_ovf = 1;
          end else m_q.push_back(dt);
        end
        m_armed = 1;
        m_last  = m_cyc;
      end
      if (m_cyc % W == W - 1) begin
        longint r;
        r = 0;
        if (m_q.size() > 0) begin
          if (m_mode == 2'b10) r = m_q[$];
          else if (m_mode == 2'b01) begin
            r = MAXV;
            foreach (m_q[i]) if (m_q[i] < r) r = m_q[i];
          end else begin
            foreach (m_q[i]) if (m_q[i] > r) r = m_q[i];
          end
        end
        e_prd     = r;
        e_edges   = (m_q.size() > 65535) ? 65535 : m_q.size();
        e_no_edge = (m_q.size() == 0);
        e_ovf     = m_ovf;
        e_valid   = 1;
        m_q.delete();
        m_ovf  = 0;
        m_mode = bus.mode;
      end
      m_cyc++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("valid",   bus.valid,   e_valid);
      chk("prd",     bus.prd,     e_prd);
      chk("edges",   bus.edges,   e_edges);
      chk("no_edge", bus.no_edge, e_no_edge);
      chk("ovf",     bus.ovf,     e_ovf);
    end
  end

  // Edge generator with alternating gaps pa,pb (pa==0: no edges).
  int gen_left = 0, gen_cur = 0, gen_last = 0;
  bit gen_tog = 0;

  task automatic gen_cycle(input int pa, input int pb);
    if (pa == 0) begin
      bus.edge_i = 1'b0;
    end else if (gen_left <= 0) begin
      bus.edge_i = 1'b1;
      gen_last = gen_cur;
      gen_cur  = gen_tog ? pb : pa;
      gen_left = gen_cur - 1;
      gen_tog  = ~gen_tog;
    end else begin
      bus.edge_i = 1'b0;
      gen_left--;
    end
  endtask

  longint pub_prd, pub_edges, pub_no_edge, pub_ovf, pub_last_gap;

  task automatic run_win(input int pa, input int pb);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        ok = 1;
        pub_prd = bus.prd; pub_edges = bus.edges;
        pub_no_edge = bus.no_edge; pub_ovf = bus.ovf;
        pub_last_gap = gen_last;
      end
      gen_cycle(pa, pb);
      if (ok) break;
    end
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  task automatic run_cycles(input int n, input int pa, input int pb);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gen_cycle(pa, pb);
    end
  endtask

  // Drives a single edge so that it lands on window offset off.
  task automatic edge_at(input int off);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (m_cyc % W == off) begin
        bus.edge_i = 1'b1;
        ok = 1;
        break;
      end
      bus.edge_i = 1'b0;
    end
    if (!ok) chk("edge_at_timeout", off, -1);
  endtask

  typedef struct {
    logic [1:0] mode;
    int         period;
    longint     exp_prd;
    int         exp_edges;
    bit         exp_no_edge;
  } vec_t;

  vec_t tab[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.edge_i = 0; bus.mode = 0; bus8.edge_i = 0; bus8.mode = 0;
    tab[0] = '{2'b00, 10, 10, 10, 0};
    tab[1] = '{2'b01, 10, 10, 10, 0};
    tab[2] = '{2'b10, 25, 25, 4, 0};
    tab[3] = '{2'b11, 20, 20, 5, 0};
    tab[4] = '{2'b01, 50, 50, 2, 0};
    tab[5] = '{2'b00, 0,  0,  0, 1};

    #1 rst_n = 0;
    #1 chk_en = 1;
    repeat (3) @(negedge clk);
    chk("rst_prd", bus.prd, 0);
    chk("rst_edges", bus.edges, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_no_edge", bus.no_edge, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst8_valid", bus8.valid, 0);
    #2 rst_n = 1;

    // 8-bit instance: 300-cycle periods saturate at 255
    begin
      int s_left, nv;
      s_left = 0; nv = 0;
      for (int i = 0; i < 6000 && nv < 4; i++) begin
        @(negedge clk);
        if (bus8.valid === 1'b1) begin
          nv++;
          if (nv >= 2) begin
            chk("sat_prd", bus8.prd, 255);
            chk("sat_ovf", bus8.ovf, 1);
            chk("sat_no_edge", bus8.no_edge, 0);
            chk("sat_edges_3or4", (bus8.edges == 3 || bus8.edges == 4), 1);
          end
        end
        bus8.edge_i = (s_left == 0);
        s_left = (s_left == 0) ? 299 : s_left - 1;
      end
      bus8.edge_i = 0;
      if (nv < 4) chk("sat_timeout", nv, 4);
    end

    foreach (tab[i]) begin
      bus.mode = tab[i].mode;
      gen_left = 0; gen_tog = 0;
      for (int w = 0; w < 4; w++) begin
        run_win(tab[i].period, tab[i].period);
        if (w >= 2) begin
          chk("tab_prd", pub_prd, tab[i].exp_prd);
          chk("tab_edges", pub_edges, tab[i].exp_edges);
          chk("tab_no_edge", pub_no_edge, tab[i].exp_no_edge);
          chk("tab_ovf", pub_ovf, 0);
        end
      end
    end

    // min over alternating 7/13, then switch to last mid-window
    bus.mode = 2'b01; gen_left = 0; gen_tog = 0;
    repeat (3) run_win(7, 13);
    chk("alt_min_prd", pub_prd, 7);
    chk("alt_min_edges", pub_edges, 10);
    run_cycles(50, 7, 13);
    bus.mode = 2'b10;
    run_win(7, 13);
    chk("switch_still_min", pub_prd, 7);
    run_win(7, 13);
    chk("switch_last", pub_prd, pub_last_gap);

    // sample landing on the win_end cycle belongs to the closing window
    bus.mode = 2'b00;
    run_win(0, 0);
    run_win(0, 0);
    edge_at(90);
    edge_at(5);  edge_at(20); edge_at(35); edge_at(50);
    edge_at(65); edge_at(79); edge_at(99);
    run_win(0, 0);
    chk("winend_prd", pub_prd, 20);
    chk("winend_edges", pub_edges, 7);
    chk("winend_no_edge", pub_no_edge, 0);
    edge_at(10);
    run_win(0, 0);
    chk("after_winend_prd", pub_prd, 11);
    chk("after_winend_edges", pub_edges, 1);

    // reset mid-window
    run_cycles(40, 0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_prd", bus.prd, 0);
    chk("midrst_edges", bus.edges, 0);
    chk("midrst_valid", bus.valid, 0);
    chk("midrst_no_edge", bus.no_edge, 0);
    chk("midrst_ovf", bus.ovf, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    edge_at(10);
    edge_at(27);
    run_win(0, 0);
    chk("rearm_prd", pub_prd, 17);
    chk("rearm_edges", pub_edges, 1);
    chk("rearm_no_edge", pub_no_edge, 0);

    // random traffic against the model
    for (int w = 0; w < 30; w++) begin
      int r, mc;
      r  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(2, 40);
      mc = $urandom_range(0, W - 1);
      for (int c = 0; c < W; c++) begin
        @(negedge clk);
        if (c == mc) bus.mode = 2'($urandom_range(0, 3));
        bus.edge_i = (r != 0) && ($urandom_range(0, r - 1) == 0);
      end
    end
    bus.edge_i = 0;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
